// File: rtl/instr_mem_loader.sv
// Instruction-memory write loader: streams words into consecutive addresses from 0 and
// holds the core in reset until a full program is loaded. Optional checksum: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
`ifdef LOADER_CHECKSUM_EN
   input  logic [DATA_W-1:0] exp_sum,
   output logic              sum_ok,
`endif
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   state_t              state_reg, state_next;
   logic                in_ready_reg, in_ready_next;
   logic                mem_we_reg, mem_we_next;
   logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
   logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
   logic                core_hold_reg, core_hold_next;
   logic                done_reg, done_next;
   logic                error_reg, error_next;
   logic [ADDR_W:0]     count_reg, count_next;
   logic [ADDR_W-1:0]   ptr_reg, ptr_next;
   logic                xfer, last_slot, sum_match;

   assign xfer      = (state_reg == S_LOAD) && in_valid && in_ready_reg;
   assign last_slot = (ptr_reg == PTR_LAST);

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_reg, sum_next;
   logic              sum_ok_reg, sum_ok_next;
   // The final word is included in the comparison on the same edge it is accepted.
   assign sum_match = ((sum_reg + in_data) == exp_sum);
   assign sum_ok    = sum_ok_reg;
`else
   assign sum_match = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_LOAD: begin
            if (xfer) begin
               if (in_last && sum_match)  state_next = S_DONE;
               else if (in_last || last_slot) state_next = S_ERR;
            end
         end
         default: if (start) state_next = S_LOAD;
      endcase
   end

   always_comb begin
      in_ready_next  = in_ready_reg;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      core_hold_next = core_hold_reg;
      done_next      = done_reg;
      error_next     = error_reg;
      count_next     = count_reg;
      ptr_next       = ptr_reg;
`ifdef LOADER_CHECKSUM_EN
      sum_next       = sum_reg;
      sum_ok_next    = sum_ok_reg;
`endif
      if (state_reg != S_LOAD && start) begin
         in_ready_next  = 1'b1;
         core_hold_next = 1'b1;
         done_next      = 1'b0;
         error_next     = 1'b0;
         count_next     = '0;
         ptr_next       = '0;
`ifdef LOADER_CHECKSUM_EN
         sum_next       = '0;
         sum_ok_next    = 1'b0;
`endif
      end else if (xfer) begin
         mem_we_next    = 1'b1;
         mem_addr_next  = ptr_reg;
         mem_wdata_next = in_data;
         count_next     = count_reg + CNT_ONE;
         // Saturate at the top slot; that transfer always leaves LOAD anyway.
         ptr_next       = last_slot ? ptr_reg : ptr_reg + PTR_ONE;
`ifdef LOADER_CHECKSUM_EN
         sum_next       = sum_reg + in_data;
`endif
         if (state_next == S_DONE) begin
            in_ready_next  = 1'b0;
            done_next      = 1'b1;
            core_hold_next = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_ok_next    = 1'b1;
`endif
         end else if (state_next == S_ERR) begin
            in_ready_next  = 1'b0;
            error_next     = 1'b1;
            core_hold_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_reg  <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         core_hold_reg <= 1'b1;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
         count_reg     <= '0;
         ptr_reg       <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_reg       <= '0;
         sum_ok_reg    <= 1'b0;
`endif
      end else begin
         in_ready_reg  <= in_ready_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
         core_hold_reg <= core_hold_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
         count_reg     <= count_next;
         ptr_reg       <= ptr_next;
`ifdef LOADER_CHECKSUM_EN
         sum_reg       <= sum_next;
         sum_ok_reg    <= sum_ok_next;
`endif
      end
   end

   assign in_ready   = in_ready_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign core_hold  = core_hold_reg;
   assign done       = done_reg;
   assign error      = error_reg;
   assign word_count = count_reg;

endmodule
